// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan readback decoder.
package seg_scan_pkg;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned BCD_W      = 4;

  typedef enum logic [0:0] {HUNT = 1'b0, TRACK = 1'b1} state_e;
  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/segment_scan_decoder_if.sv
// Display-bus monitor interface: scan inputs in, committed frame and status out.
interface segment_scan_decoder_if;
  import seg_scan_pkg::*;

  bcd_t                  data;
  logic [NUM_DIGITS-1:0] seg_sel;
  logic                  clr_err;
  bcd_t                  digit0, digit1, digit2, digit3, digit4, digit5;
  logic                  frame_valid;
  logic                  frame_done;
  logic                  err_onehot;
  logic                  err_order;
  logic                  stale;

  modport master (
    output data, seg_sel, clr_err,
    input  digit0, digit1, digit2, digit3, digit4, digit5,
    input  frame_valid, frame_done, err_onehot, err_order, stale
  );

  modport slave (
    input  data, seg_sel, clr_err,
    output digit0, digit1, digit2, digit3, digit4, digit5,
    output frame_valid, frame_done, err_onehot, err_order, stale
  );
endinterface

// File: rtl/seg_sel_decode.sv
// Classifies a digit select as blank, one-hot (with digit index) or invalid.
module seg_sel_decode
  import seg_scan_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] sel,
  output logic                  valid,
  output logic                  blank,
  output logic                  invalid,
  output idx_t                  index
);

  // MSB of the select is digit 0, LSB is the last digit.
  always_comb begin
    blank   = (sel == '0);
    valid   = $onehot(sel);
    invalid = !blank && !valid;
    index   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) index = IDX_W'(NUM_DIGITS - 1 - i);
    end
  end

endmodule

// File: rtl/segment_scan_decoder.sv
// Rebuilds the six displayed BCD digits from the multiplexed scan bus and
// publishes one coherent frame per complete in-order scan.
module segment_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_TIMEOUT = 2048
) (
  input logic                   clk,
  input logic                   reset,
  segment_scan_decoder_if.slave bus
);

  localparam int unsigned DW         = $clog2(SCAN_TIMEOUT + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_TIMEOUT);
  localparam idx_t          LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [0:0]    ST_HUNT   = HUNT;
  localparam logic [0:0]    ST_TRACK  = TRACK;

  bcd_t                  data_r;
  logic [NUM_DIGITS-1:0] sel_r;
  logic                  sel_valid, sel_blank, sel_invalid;
  idx_t                  sel_idx;

  logic [0:0]    state, state_n;
  idx_t          cur, cur_n;
  idx_t          last_idx, last_n;
  logic [DW-1:0] dwell, dwell_n;
  bcd_t          shadow [NUM_DIGITS];

  logic idx_chg, commit, cap;
  logic fv_n, stale_n, err_onehot_n, err_order_n;

  seg_sel_decode u_dec (
    .sel     (sel_r),
    .valid   (sel_valid),
    .blank   (sel_blank),
    .invalid (sel_invalid),
    .index   (sel_idx)
  );

  assign cap = !sel_blank && !sel_invalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_HUNT;
    else        state <= state_n;
  end

  // Order tracking, dwell timeout and flag next-state.
  always_comb begin
    state_n   = state;
    cur_n     = cur;
    last_n    = last_idx;
    dwell_n   = dwell;
    commit    = 1'b0;
    fv_n      = bus.frame_valid;
    stale_n   = bus.stale;
    idx_chg   = sel_valid && (sel_idx != last_idx);

    if (idx_chg)                dwell_n = '0;
    else if (dwell != DWELL_MAX) dwell_n = DW'(dwell + 1'b1);

    if (sel_valid) last_n = sel_idx;

    err_order_n  = bus.err_order && !bus.clr_err;
    err_onehot_n = (bus.err_onehot && !bus.clr_err) || sel_invalid;

    case (state)
      ST_HUNT: begin
        if (sel_valid && sel_idx == '0) begin
          state_n = ST_TRACK;
          cur_n   = '0;
        end
      end
      ST_TRACK: begin
        if (sel_valid && sel_idx != cur) begin
          if (cur != LAST_IDX && sel_idx == IDX_W'(cur + 1'b1)) begin
            cur_n = sel_idx;
          end else if (cur == LAST_IDX && sel_idx == '0) begin
            commit = 1'b1;
            fv_n   = 1'b1;
            cur_n  = '0;
          end else begin
            err_order_n = 1'b1;
            state_n     = ST_HUNT;
          end
        end
      end
      default: state_n = ST_HUNT;
    endcase

    if (sel_invalid) state_n = ST_HUNT;
    if (idx_chg)     stale_n = 1'b0;

    // A scan that stops moving invalidates the published frame.
    if (dwell_n == DWELL_MAX) begin
      stale_n = 1'b1;
      fv_n    = 1'b0;
      state_n = ST_HUNT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r          <= '0;
      sel_r           <= '0;
      cur             <= '0;
      last_idx        <= '0;
      dwell           <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
      bus.digit0      <= '0;
      bus.digit1      <= '0;
      bus.digit2      <= '0;
      bus.digit3      <= '0;
      bus.digit4      <= '0;
      bus.digit5      <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.err_onehot  <= 1'b0;
      bus.err_order   <= 1'b0;
      bus.stale       <= 1'b0;
    end else begin
      data_r          <= bus.data;
      sel_r           <= bus.seg_sel;
      cur             <= cur_n;
      last_idx        <= last_n;
      dwell           <= dwell_n;
      if (cap) shadow[sel_idx] <= data_r;
      if (commit) begin
        bus.digit0 <= shadow[0];
        bus.digit1 <= shadow[1];
        bus.digit2 <= shadow[2];
        bus.digit3 <= shadow[3];
        bus.digit4 <= shadow[4];
        bus.digit5 <= shadow[5];
      end
      bus.frame_valid <= fv_n;
      bus.frame_done  <= commit;
      bus.err_onehot  <= err_onehot_n;
      bus.err_order   <= err_order_n;
      bus.stale       <= stale_n;
    end
  end

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed self-checking bench for segment_scan_decoder (default and short timeout).
module tb_segment_scan_decoder;
  import seg_scan_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  segment_scan_decoder_if b ();
  segment_scan_decoder_if bs ();

  segment_scan_decoder u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  segment_scan_decoder #(.SCAN_TIMEOUT(16)) u_dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bs.slave)
  );

  always @(negedge clk) if (b.frame_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] s, input logic [3:0] d, input int n);
    b.seg_sel  = s;
    bs.seg_sel = s;
    b.data     = d;
    bs.data    = d;
    tick(n);
  endtask

  task automatic set_clr(input logic c);
    b.clr_err  = c;
    bs.clr_err = c;
  endtask

  function automatic logic [5:0] sel_of(input int i);
    logic [5:0] top = 6'b10_0000;
    return top >> i;
  endfunction

  // Digits 0..5 in order; a wrong value leads each dwell so the last sample must win.
  task automatic scan05(input logic [23:0] v, input int dwell, input int blanks);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] d;
      d = v[4*(5-i) +: 4];
      drive(sel_of(i), d ^ 4'h5, 1);
      drive(sel_of(i), d, dwell - 1);
      if (blanks > 0) drive(6'b00_0000, 4'hE, blanks);
    end
  endtask

  function automatic logic [31:0] dig_m();
    return 32'({b.digit0, b.digit1, b.digit2, b.digit3, b.digit4, b.digit5});
  endfunction

  function automatic logic [31:0] dig_s();
    return 32'({bs.digit0, bs.digit1, bs.digit2, bs.digit3, bs.digit4, bs.digit5});
  endfunction

  function automatic logic [31:0] flags_m();
    return 32'({b.frame_valid, b.frame_done, b.err_onehot, b.err_order, b.stale});
  endfunction

  initial begin
    reset = 1'b1;
    set_clr(1'b0);
    b.seg_sel = '0; bs.seg_sel = '0; b.data = '0; bs.data = '0;
    #2 reset = 1'b0;
    tick(3);
    check("reset_digits", dig_m(), 32'h0);
    check("reset_flags", flags_m(), 32'h0);
    reset = 1'b1;
    tick(2);

    // Clean scan at 1024 cycles per digit
    scan05(24'h123456, 1024, 0);
    drive(6'b10_0000, 4'h7, 1);
    check("done_early", 32'(b.frame_done), 32'h0);
    tick(1);
    check("done_pulse", 32'(b.frame_done), 32'h1);
    check("digits_clean", dig_m(), 32'h123456);
    check("fv_clean", 32'(b.frame_valid), 32'h1);
    check("errs_clean", 32'({b.err_onehot, b.err_order, b.stale}), 32'h0);
    tick(1);
    check("done_one_cycle", 32'(b.frame_done), 32'h0);
    check("done_cnt_clean", 32'(done_cnt), 32'h1);

    // Order error: 0,1,3
    drive(6'b01_0000, 4'h1, 4);
    drive(6'b00_0100, 4'h3, 1);
    check("order_early", 32'(b.err_order), 32'h0);
    tick(1);
    check("order_err", 32'(b.err_order), 32'h1);
    drive(6'b00_0100, 4'h3, 2);
    drive(6'b00_0010, 4'h4, 4);
    drive(6'b00_0001, 4'h5, 4);
    drive(6'b10_0000, 4'h8, 4);
    check("order_nocommit", 32'(done_cnt), 32'h1);
    scan05(24'h864201, 4, 0);
    drive(6'b10_0000, 4'h0, 3);
    check("order_commit_cnt", 32'(done_cnt), 32'h2);
    check("order_digits", dig_m(), 32'h864201);
    set_clr(1'b1);
    tick(1);
    set_clr(1'b0);
    check("order_clr", 32'(b.err_order), 32'h0);

    // Multi-hot select mid-frame
    drive(6'b01_0000, 4'h2, 4);
    drive(6'b00_1000, 4'h3, 4);
    drive(6'b10_0100, 4'h1, 1);
    drive(6'b00_0100, 4'h4, 1);
    check("onehot_err", 32'(b.err_onehot), 32'h1);
    check("onehot_fv_kept", 32'(b.frame_valid), 32'h1);
    drive(6'b00_0100, 4'h4, 3);
    drive(6'b00_0010, 4'h5, 4);
    drive(6'b00_0001, 4'h6, 4);
    drive(6'b10_0000, 4'h7, 4);
    check("onehot_nocommit", 32'(done_cnt), 32'h2);
    check("onehot_digits_kept", dig_m(), 32'h864201);
    drive(6'b10_0100, 4'h0, 1);
    set_clr(1'b1);
    drive(6'b10_0000, 4'h7, 1);
    set_clr(1'b0);
    check("onehot_err_wins", 32'(b.err_onehot), 32'h1);
    set_clr(1'b1);
    tick(1);
    set_clr(1'b0);
    check("onehot_clr", 32'(b.err_onehot), 32'h0);
    scan05(24'h135790, 4, 0);
    drive(6'b10_0000, 4'h1, 3);
    check("onehot_recommit", dig_m(), 32'h135790);
    check("onehot_recommit_cnt", 32'(done_cnt), 32'h3);

    // Stall on the short-timeout instance
    scan05(24'h987654, 4, 0);
    drive(6'b10_0000, 4'h9, 3);
    scan05(24'h987654, 4, 0);
    drive(6'b10_0000, 4'h9, 3);
    check("stall_pre_digits", dig_s(), 32'h987654);
    check("stall_pre_fv", 32'(bs.frame_valid), 32'h1);
    drive(6'b01_0000, 4'h8, 4);
    drive(6'b00_1000, 4'h7, 17);
    check("stall_early", 32'(bs.stale), 32'h0);
    tick(1);
    check("stall_stale", 32'(bs.stale), 32'h1);
    check("stall_fv", 32'(bs.frame_valid), 32'h0);
    check("stall_digits_kept", dig_s(), 32'h987654);
    tick(2);
    check("stall_main_fv", 32'(b.frame_valid), 32'h1);
    check("stall_main_stale", 32'(b.stale), 32'h0);

    // Reset mid-frame, then a scan with blank gaps
    drive(6'b00_0100, 4'h3, 2);
    reset = 1'b0;
    #1;
    check("rst_digits", dig_m(), 32'h0);
    check("rst_flags", flags_m(), 32'h0);
    tick(2);
    reset = 1'b1;
    scan05(24'h246813, 4, 2);
    drive(6'b10_0000, 4'h5, 3);
    check("blank_digits", dig_m(), 32'h246813);
    check("blank_fv", 32'(b.frame_valid), 32'h1);
    check("blank_errs", 32'({b.err_onehot, b.err_order}), 32'h0);
    check("done_total", 32'(done_cnt), 32'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
